// File: rtl/dtlb_miss_ctrl_if.sv
// rtl/dtlb_miss_ctrl_if.sv - DTLB miss controller port bundle (LSU, CAM, PTW memory port)
interface dtlb_miss_ctrl_if #(
    parameter int IDX_W    = 5,
    parameter int PA_WIDTH = 34
);
    // LSU lookup side
    logic                req_valid;
    logic [19:0]         req_vpn;
    logic                req_ready;
    logic                resp_valid;
    logic [21:0]         resp_ppn;
    logic [3:0]          resp_perm;
    logic                resp_fault;
    logic                trans_off;
    logic [21:0]         satp_ppn;
    logic                flush_req;
    logic                flush_done;
    // DTLB CAM side
    logic                tlb_re;
    logic [19:0]         tlb_vpn;
    logic                tlb_trans_off;
    logic                tlb_we;
    logic [IDX_W-1:0]    tlb_waddr;
    logic [51:0]         tlb_wdata;
    logic                tlb_miss;
    logic                tlb_valid_data;
    logic [25:0]         tlb_data;
    // page-table walk read port
    logic                mem_req;
    logic [PA_WIDTH-1:0] mem_addr;
    logic                mem_gnt;
    logic                mem_rvalid;
    logic [31:0]         mem_rdata;

    modport slave (
        input  req_valid, req_vpn, trans_off, satp_ppn, flush_req,
        input  tlb_miss, tlb_valid_data, tlb_data,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_ppn, resp_perm, resp_fault, flush_done,
        output tlb_re, tlb_vpn, tlb_trans_off, tlb_we, tlb_waddr, tlb_wdata,
        output mem_req, mem_addr
    );

    modport master (
        output req_valid, req_vpn, trans_off, satp_ppn, flush_req,
        output tlb_miss, tlb_valid_data, tlb_data,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_ppn, resp_perm, resp_fault, flush_done,
        input  tlb_re, tlb_vpn, tlb_trans_off, tlb_we, tlb_waddr, tlb_wdata,
        input  mem_req, mem_addr
    );
endinterface

// File: rtl/dtlb_miss_ctrl.sv
// rtl/dtlb_miss_ctrl.sv - DTLB lookup sequencer with Sv32 page-table walk, round-robin refill and flush
module dtlb_miss_ctrl #(
    parameter int TLB_DEPTH = 32,
    parameter int PA_WIDTH  = 34
) (
    input  logic              clk,
    input  logic              rst,
    dtlb_miss_ctrl_if.slave   bus
);
    localparam int IDX_W = $clog2(TLB_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_DEPTH - 1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LOOKUP  = 4'd1;
    localparam logic [3:0] S_CHECK   = 4'd2;
    localparam logic [3:0] S_L1_REQ  = 4'd3;
    localparam logic [3:0] S_L1_WAIT = 4'd4;
    localparam logic [3:0] S_L0_REQ  = 4'd5;
    localparam logic [3:0] S_L0_WAIT = 4'd6;
    localparam logic [3:0] S_REFILL  = 4'd7;
    localparam logic [3:0] S_RESP    = 4'd8;
    localparam logic [3:0] S_FLUSH   = 4'd9;

    logic [3:0]       state_q, state_d;
    logic [19:0]      vpn_q, vpn_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             flush_pend_q, flush_pend_d;
    logic [IDX_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [21:0]      l0_base_q, l0_base_d;      // next-level table PPN from the L1 pointer PTE
    logic [21:0]      ref_ppn_q, ref_ppn_d;      // PPN to be written on refill
    logic [9:0]       ref_bits_q, ref_bits_d;    // low PTE flag bits to be written on refill
    logic [21:0]      resp_ppn_q, resp_ppn_d;
    logic [3:0]       resp_perm_q, resp_perm_d;
    logic             resp_fault_q, resp_fault_d;

    logic             take_fault;
    logic             pte_bad;
    logic             pte_ptr;

    // PTE classification: invalid or reserved R=0/W=1 encodings, and pointer (no RWX)
    always_comb begin
        pte_bad = !bus.mem_rdata[0] || (!bus.mem_rdata[1] && bus.mem_rdata[2]);
        pte_ptr = bus.mem_rdata[0] && (bus.mem_rdata[3:1] == 3'b000);
    end

    // Next-state and datapath updates for the lookup / walk / flush sequencer
    always_comb begin
        state_d      = state_q;
        vpn_d        = vpn_q;
        rr_ptr_d     = rr_ptr_q;
        flush_pend_d = flush_pend_q;
        flush_cnt_d  = flush_cnt_q;
        l0_base_d    = l0_base_q;
        ref_ppn_d    = ref_ppn_q;
        ref_bits_d   = ref_bits_q;
        resp_ppn_d   = resp_ppn_q;
        resp_perm_d  = resp_perm_q;
        resp_fault_d = resp_fault_q;
        take_fault   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.flush_req || flush_pend_q) begin
                    flush_cnt_d = '0;
                    state_d     = S_FLUSH;
                end else if (bus.req_valid) begin
                    vpn_d   = bus.req_vpn;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = S_CHECK;
            S_CHECK: begin
                if (bus.tlb_valid_data) begin
                    resp_ppn_d   = bus.tlb_data[25:4];
                    resp_perm_d  = bus.tlb_data[3:0];
                    resp_fault_d = 1'b0;
                    state_d      = S_RESP;
                end else if (bus.tlb_miss) begin
                    // bare mode never walks; a CAM miss there is reported as a fault
                    if (bus.trans_off) take_fault = 1'b1;
                    else               state_d    = S_L1_REQ;
                end
            end
            S_L1_REQ: if (bus.mem_gnt) state_d = S_L1_WAIT;
            S_L1_WAIT: begin
                if (bus.mem_rvalid) begin
                    if (pte_bad) begin
                        take_fault = 1'b1;
                    end else if (pte_ptr) begin
                        l0_base_d = bus.mem_rdata[31:10];
                        state_d   = S_L0_REQ;
                    end else if (bus.mem_rdata[19:10] != 10'd0) begin
                        take_fault = 1'b1;
                    end else begin
                        ref_ppn_d  = {bus.mem_rdata[31:20], vpn_q[9:0]};
                        ref_bits_d = bus.mem_rdata[9:0];
                        state_d    = S_REFILL;
                    end
                end
            end
            S_L0_REQ: if (bus.mem_gnt) state_d = S_L0_WAIT;
            S_L0_WAIT: begin
                if (bus.mem_rvalid) begin
                    if (pte_bad || pte_ptr) begin
                        take_fault = 1'b1;
                    end else begin
                        ref_ppn_d  = bus.mem_rdata[31:10];
                        ref_bits_d = bus.mem_rdata[9:0];
                        state_d    = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                rr_ptr_d = (rr_ptr_q == LAST_IDX) ? '0 : rr_ptr_q + IDX_W'(1);
                state_d  = S_LOOKUP;
            end
            S_RESP: state_d = S_IDLE;
            S_FLUSH: begin
                if (flush_cnt_q == LAST_IDX) begin
                    rr_ptr_d     = '0;
                    flush_pend_d = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (take_fault) begin
            resp_ppn_d   = '0;
            resp_perm_d  = '0;
            resp_fault_d = 1'b1;
            state_d      = S_RESP;
        end

        // a flush arriving mid-request is remembered and run once the request answers
        if (bus.flush_req && (state_q != S_IDLE) && (state_q != S_FLUSH)) flush_pend_d = 1'b1;
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            vpn_q        <= '0;
            rr_ptr_q     <= '0;
            flush_pend_q <= 1'b0;
            flush_cnt_q  <= '0;
            l0_base_q    <= '0;
            ref_ppn_q    <= '0;
            ref_bits_q   <= '0;
            resp_ppn_q   <= '0;
            resp_perm_q  <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vpn_q        <= vpn_d;
            rr_ptr_q     <= rr_ptr_d;
            flush_pend_q <= flush_pend_d;
            flush_cnt_q  <= flush_cnt_d;
            l0_base_q    <= l0_base_d;
            ref_ppn_q    <= ref_ppn_d;
            ref_bits_q   <= ref_bits_d;
            resp_ppn_q   <= resp_ppn_d;
            resp_perm_q  <= resp_perm_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    // Outputs decoded from the current state; everything idles at zero
    always_comb begin
        bus.req_ready     = (state_q == S_IDLE) && !flush_pend_q && !bus.flush_req;
        bus.resp_valid    = (state_q == S_RESP);
        bus.resp_ppn      = resp_ppn_q;
        bus.resp_perm     = resp_perm_q;
        bus.resp_fault    = resp_fault_q;
        bus.flush_done    = (state_q == S_FLUSH) && (flush_cnt_q == LAST_IDX);
        bus.tlb_re        = (state_q == S_LOOKUP);
        bus.tlb_vpn       = '0;
        bus.tlb_trans_off = 1'b0;
        bus.tlb_we        = 1'b0;
        bus.tlb_waddr     = '0;
        bus.tlb_wdata     = '0;
        bus.mem_req       = 1'b0;
        bus.mem_addr      = '0;
        case (state_q)
            S_LOOKUP: begin
                bus.tlb_vpn       = vpn_q;
                bus.tlb_trans_off = bus.trans_off;
            end
            S_REFILL: begin
                bus.tlb_we    = 1'b1;
                bus.tlb_waddr = rr_ptr_q;
                bus.tlb_wdata = {vpn_q, ref_ppn_q, ref_bits_q};
            end
            S_FLUSH: begin
                bus.tlb_we    = 1'b1;
                bus.tlb_waddr = flush_cnt_q;
            end
            S_L1_REQ: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = PA_WIDTH'({bus.satp_ppn, vpn_q[19:10], 2'b00});
            end
            S_L0_REQ: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = PA_WIDTH'({l0_base_q, vpn_q[9:0], 2'b00});
            end
            default: ;
        endcase
    end
endmodule
